// File: rtl/reg_writeback_queue_if.sv
// Signal bundle between a writeback producer, the writeback queue and the
// register file write/read ports.
interface reg_writeback_queue_if #(
    parameter int DEPTH = 4
);
    localparam int CW = $clog2(DEPTH) + 1;

    logic          in_valid;
    logic          in_ready;
    logic [3:0]    in_rd;
    logic [15:0]   in_data;
    logic          hold;
    logic          wr;
    logic [3:0]    Rd;
    logic [15:0]   RW;
    logic [3:0]    Rs;
    logic [3:0]    Rt;
    logic          fwd1_hit;
    logic          fwd2_hit;
    logic [15:0]   fwd1_data;
    logic [15:0]   fwd2_data;
    logic [CW-1:0] count;
    logic          full;
    logic          empty;

    modport master (
        output in_valid, in_rd, in_data, hold, Rs, Rt,
        input  in_ready, wr, Rd, RW, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
               count, full, empty
    );

    modport slave (
        input  in_valid, in_rd, in_data, hold, Rs, Rt,
        output in_ready, wr, Rd, RW, fwd1_hit, fwd2_hit, fwd1_data, fwd2_data,
               count, full, empty
    );
endinterface

// File: rtl/reg_writeback_queue.sv
// Circular writeback queue in front of the register file write port, with
// youngest-first forwarding of pending values to the two read indices.
module reg_writeback_queue #(
    parameter int DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst,
    reg_writeback_queue_if.slave bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [3:0]    r_memRd   [DEPTH];
    logic [15:0]   r_memData [DEPTH];
    logic [PW-1:0] r_head;
    logic [PW-1:0] r_tail;
    logic [CW-1:0] r_count;
    logic          r_wr;
    logic [3:0]    r_rd;
    logic [15:0]   r_rw;

    logic          w_full;
    logic          w_empty;
    logic          w_push;
    logic          w_pop;
    logic [PW-1:0] w_idx;
    logic          w_fwd1Hit;
    logic          w_fwd2Hit;
    logic [15:0]   w_fwd1Data;
    logic [15:0]   w_fwd2Data;

    assign w_full  = (r_count == CW'(DEPTH));
    assign w_empty = (r_count == '0);
    assign w_push  = bus.in_valid && !w_full;
    // Pop only looks at entries already present, so a fresh push waits an edge.
    assign w_pop   = !w_empty && !bus.hold;

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_memRd[r_tail]   <= bus.in_rd;
            r_memData[r_tail] <= bus.in_data;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_head  <= '0;
            r_tail  <= '0;
            r_count <= '0;
            r_wr    <= 1'b0;
            r_rd    <= '0;
            r_rw    <= '0;
        end else begin
            if (w_push) begin
                r_tail <= r_tail + PW'(1);
            end
            if (w_pop) begin
                r_head <= r_head + PW'(1);
                r_wr   <= 1'b1;
                r_rd   <= r_memRd[r_head];
                r_rw   <= r_memData[r_head];
            end else begin
                r_wr   <= 1'b0;
            end
            case ({w_push, w_pop})
                2'b10:   r_count <= r_count + CW'(1);
                2'b01:   r_count <= r_count - CW'(1);
                default: r_count <= r_count;
            endcase
        end
    end

    // Scan oldest to youngest so later matches override; output stage is oldest.
    always_comb begin
        w_idx      = '0;
        w_fwd1Hit  = r_wr && (r_rd == bus.Rs);
        w_fwd2Hit  = r_wr && (r_rd == bus.Rt);
        w_fwd1Data = w_fwd1Hit ? r_rw : '0;
        w_fwd2Data = w_fwd2Hit ? r_rw : '0;
        for (int k = 0; k < DEPTH; k++) begin
            w_idx = r_head + PW'(k);
            if (CW'(k) < r_count) begin
                if (r_memRd[w_idx] == bus.Rs) begin
                    w_fwd1Hit  = 1'b1;
                    w_fwd1Data = r_memData[w_idx];
                end
                if (r_memRd[w_idx] == bus.Rt) begin
                    w_fwd2Hit  = 1'b1;
                    w_fwd2Data = r_memData[w_idx];
                end
            end
        end
    end

    assign bus.in_ready  = !w_full;
    assign bus.wr        = r_wr;
    assign bus.Rd        = r_rd;
    assign bus.RW        = r_rw;
    assign bus.count     = r_count;
    assign bus.full      = w_full;
    assign bus.empty     = w_empty;
    assign bus.fwd1_hit  = w_fwd1Hit;
    assign bus.fwd2_hit  = w_fwd2Hit;
    assign bus.fwd1_data = w_fwd1Data;
    assign bus.fwd2_data = w_fwd2Data;
endmodule

// File: tb/tb_reg_writeback_queue.sv
// Self-checking bench for reg_writeback_queue: a queue-level reference model
// compared every cycle, plus directed scenarios with literal expectations.
module tb_reg_writeback_queue;
    localparam int DEPTH = 4;

    typedef struct packed {
        logic [3:0]  rd;
        logic [15:0] data;
    } entry_t;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   errors = 0;
    int   checks = 0;

    entry_t      mq[$];
    logic        mWr = 1'b0;
    logic [3:0]  mRd = '0;
    logic [15:0] mRw = '0;

    reg_writeback_queue_if #(.DEPTH(DEPTH)) bus ();

    reg_writeback_queue #(.DEPTH(DEPTH)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
        checks++;
        if (actual !== expected) begin
            errors++;
            $display("[TB] FAIL %s at %0t: got 0x%0h, expected 0x%0h", name, $time, actual, expected);
        end
    endtask

    task automatic applyStimulus(input logic v, input logic [3:0] rd, input logic [15:0] data,
                                 input logic h, input logic [3:0] rs, input logic [3:0] rt);
        bus.in_valid = v;
        bus.in_rd    = rd;
        bus.in_data  = data;
        bus.hold     = h;
        bus.Rs       = rs;
        bus.Rt       = rt;
        @(posedge clk);
        #1;
    endtask

    // Reference: FIFO of accepted writebacks plus a one-deep output stage.
    always @(posedge clk or negedge rst) begin
        if (!rst) begin
            mq.delete();
            mWr <= 1'b0;
            mRd <= '0;
            mRw <= '0;
        end else if (mq.size() != 0 && !bus.hold) begin
            mWr <= 1'b1;
            mRd <= mq[0].rd;
            mRw <= mq[0].data;
            if (bus.in_valid && mq.size() < DEPTH) mq.push_back({bus.in_rd, bus.in_data});
            void'(mq.pop_front());
        end else begin
            mWr <= 1'b0;
            if (bus.in_valid && mq.size() < DEPTH) mq.push_back({bus.in_rd, bus.in_data});
        end
    end

    function automatic logic [16:0] expectFwd(input logic [3:0] r);
        for (int i = mq.size() - 1; i >= 0; i--) begin
            if (mq[i].rd == r) return {1'b1, mq[i].data};
        end
        if (mWr && mRd == r) return {1'b1, mRw};
        return 17'd0;
    endfunction

    task automatic compareModel();
        logic [16:0] f1;
        logic [16:0] f2;
        f1 = expectFwd(bus.Rs);
        f2 = expectFwd(bus.Rt);
        checkOutput("model wr",        32'(bus.wr),        32'(mWr));
        checkOutput("model Rd",        32'(bus.Rd),        32'(mRd));
        checkOutput("model RW",        32'(bus.RW),        32'(mRw));
        checkOutput("model count",     32'(bus.count),     32'(mq.size()));
        checkOutput("model full",      32'(bus.full),      32'(mq.size() == DEPTH));
        checkOutput("model empty",     32'(bus.empty),     32'(mq.size() == 0));
        checkOutput("model in_ready",  32'(bus.in_ready),  32'(mq.size() < DEPTH));
        checkOutput("model fwd1_hit",  32'(bus.fwd1_hit),  32'(f1[16]));
        checkOutput("model fwd1_data", 32'(bus.fwd1_data), 32'(f1[15:0]));
        checkOutput("model fwd2_hit",  32'(bus.fwd2_hit),  32'(f2[16]));
        checkOutput("model fwd2_data", 32'(bus.fwd2_data), 32'(f2[15:0]));
    endtask

    always @(negedge clk) compareModel();

    initial begin
        #200000;
        $display("[TB] FAIL watchdog: simulation did not finish, errors=%0d", errors);
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        bus.in_valid = 1'b0;
        bus.in_rd    = '0;
        bus.in_data  = '0;
        bus.hold     = 1'b0;
        bus.Rs       = '0;
        bus.Rt       = '0;
        #1 rst = 1'b0;
        #1;
        $display("[TB] reset state");
        checkOutput("reset wr",       32'(bus.wr),       32'd0);
        checkOutput("reset Rd",       32'(bus.Rd),       32'd0);
        checkOutput("reset RW",       32'(bus.RW),       32'd0);
        checkOutput("reset count",    32'(bus.count),    32'd0);
        checkOutput("reset empty",    32'(bus.empty),    32'd1);
        checkOutput("reset full",     32'(bus.full),     32'd0);
        checkOutput("reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("reset fwd1_hit", 32'(bus.fwd1_hit), 32'd0);
        checkOutput("reset fwd2_hit", 32'(bus.fwd2_hit), 32'd0);
        #1 rst = 1'b1;

        $display("[TB] single write");
        applyStimulus(1'b1, 4'd3, 16'hBEEF, 1'b0, 4'd0, 4'd0);
        checkOutput("single count after push", 32'(bus.count), 32'd1);
        checkOutput("single wr after push",    32'(bus.wr),    32'd0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);
        checkOutput("single wr",  32'(bus.wr), 32'd1);
        checkOutput("single Rd",  32'(bus.Rd), 32'd3);
        checkOutput("single RW",  32'(bus.RW), 32'hBEEF);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);
        checkOutput("single wr low",  32'(bus.wr), 32'd0);
        checkOutput("single Rd held", 32'(bus.Rd), 32'd3);
        checkOutput("single RW held", 32'(bus.RW), 32'hBEEF);

        $display("[TB] full queue");
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b1, 4'(k), 16'(k * 16'h1111), 1'b1, 4'd0, 4'd0);
        end
        checkOutput("full count",    32'(bus.count),    32'd4);
        checkOutput("full flag",     32'(bus.full),     32'd1);
        checkOutput("full in_ready", 32'(bus.in_ready), 32'd0);
        applyStimulus(1'b1, 4'd9, 16'h9999, 1'b1, 4'd0, 4'd0);
        checkOutput("full 5th ignored count", 32'(bus.count), 32'd4);
        checkOutput("full hold wr",           32'(bus.wr),    32'd0);
        checkOutput("full hold Rd stable",    32'(bus.Rd),    32'd3);
        checkOutput("full hold RW stable",    32'(bus.RW),    32'hBEEF);
        for (int k = 1; k <= 4; k++) begin
            applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);
            checkOutput("drain wr", 32'(bus.wr), 32'd1);
            checkOutput("drain Rd", 32'(bus.Rd), 32'(k));
            checkOutput("drain RW", 32'(bus.RW), 32'(16'(k * 16'h1111)));
        end
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);
        checkOutput("drain done wr",    32'(bus.wr),    32'd0);
        checkOutput("drain done empty", 32'(bus.empty), 32'd1);

        $display("[TB] forwarding priority");
        applyStimulus(1'b1, 4'd5, 16'h0001, 1'b1, 4'd5, 4'd6);
        checkOutput("prio first fwd1_data", 32'(bus.fwd1_data), 32'h0001);
        applyStimulus(1'b1, 4'd5, 16'h0002, 1'b1, 4'd5, 4'd6);
        checkOutput("prio fwd1_hit",  32'(bus.fwd1_hit),  32'd1);
        checkOutput("prio fwd1_data", 32'(bus.fwd1_data), 32'h0002);
        checkOutput("prio fwd2_hit",  32'(bus.fwd2_hit),  32'd0);
        checkOutput("prio fwd2_data", 32'(bus.fwd2_data), 32'd0);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 4'd6);
        checkOutput("prio queue over stage RW",   32'(bus.RW),        32'h0001);
        checkOutput("prio queue over stage fwd1", 32'(bus.fwd1_data), 32'h0002);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd5, 4'd6);
        checkOutput("prio last RW",   32'(bus.RW),        32'h0002);
        checkOutput("prio last fwd1", 32'(bus.fwd1_data), 32'h0002);

        $display("[TB] output-stage forwarding");
        applyStimulus(1'b1, 4'd7, 16'h1234, 1'b0, 4'd7, 4'd0);
        checkOutput("stage queued fwd1_data", 32'(bus.fwd1_data), 32'h1234);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd7, 4'd0);
        checkOutput("stage wr",        32'(bus.wr),        32'd1);
        checkOutput("stage Rd",        32'(bus.Rd),        32'd7);
        checkOutput("stage empty",     32'(bus.empty),     32'd1);
        checkOutput("stage fwd1_hit",  32'(bus.fwd1_hit),  32'd1);
        checkOutput("stage fwd1_data", 32'(bus.fwd1_data), 32'h1234);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd7, 4'd0);
        checkOutput("stage gone fwd1_hit",  32'(bus.fwd1_hit),  32'd0);
        checkOutput("stage gone fwd1_data", 32'(bus.fwd1_data), 32'd0);

        $display("[TB] simultaneous push/pop with wrap");
        applyStimulus(1'b1, 4'd0, 16'hA000, 1'b1, 4'd0, 4'd1);
        applyStimulus(1'b1, 4'd1, 16'hA001, 1'b1, 4'd0, 4'd1);
        checkOutput("pp start count", 32'(bus.count), 32'd2);
        for (int i = 0; i < 10; i++) begin
            applyStimulus(1'b1, 4'(i + 2), 16'(16'hA000 + i + 2), 1'b0, 4'd0, 4'd1);
            checkOutput("pp count", 32'(bus.count), 32'd2);
            checkOutput("pp wr",    32'(bus.wr),    32'd1);
            checkOutput("pp Rd",    32'(bus.Rd),    32'(i));
            checkOutput("pp RW",    32'(bus.RW),    32'(16'(16'hA000 + i)));
        end
        for (int i = 10; i < 12; i++) begin
            applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd1);
            checkOutput("pp tail Rd", 32'(bus.Rd), 32'(i));
            checkOutput("pp tail RW", 32'(bus.RW), 32'(16'(16'hA000 + i)));
        end
        checkOutput("pp empty", 32'(bus.empty), 32'd1);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd1);

        $display("[TB] reset mid-operation");
        applyStimulus(1'b1, 4'd8,  16'hC008, 1'b1, 4'd9, 4'd10);
        applyStimulus(1'b1, 4'd9,  16'hC009, 1'b1, 4'd9, 4'd10);
        applyStimulus(1'b1, 4'd10, 16'hC00A, 1'b1, 4'd9, 4'd10);
        applyStimulus(1'b1, 4'd11, 16'hC00B, 1'b0, 4'd9, 4'd10);
        checkOutput("mid count before", 32'(bus.count), 32'd3);
        checkOutput("mid wr before",    32'(bus.wr),    32'd1);
        bus.in_valid = 1'b0;
        #2 rst = 1'b0;
        #1;
        checkOutput("mid reset wr",       32'(bus.wr),       32'd0);
        checkOutput("mid reset count",    32'(bus.count),    32'd0);
        checkOutput("mid reset empty",    32'(bus.empty),    32'd1);
        checkOutput("mid reset in_ready", 32'(bus.in_ready), 32'd1);
        checkOutput("mid reset RW",       32'(bus.RW),       32'd0);
        checkOutput("mid reset fwd1_hit", 32'(bus.fwd1_hit), 32'd0);
        @(negedge clk);
        #1 rst = 1'b1;
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd9, 4'd10);
            checkOutput("post reset no wr", 32'(bus.wr), 32'd0);
        end
        applyStimulus(1'b1, 4'd2, 16'h5A5A, 1'b0, 4'd2, 4'd10);
        checkOutput("post reset push count", 32'(bus.count), 32'd1);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd2, 4'd10);
        checkOutput("post reset Rd", 32'(bus.Rd), 32'd2);
        checkOutput("post reset RW", 32'(bus.RW), 32'h5A5A);
        applyStimulus(1'b0, 4'd0, 16'h0000, 1'b0, 4'd0, 4'd0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/reg_writeback_queue.md
REG_WRITEBACK_QUEUE -- requirements
Module: reg_writeback_queue

Interface
REQ-001 SHALL have parameter DEPTH, default 4, meaning the number of queued writeback entries (power of two, 2..16).
REQ-002 SHALL have port clk  input  1  the single clock; all state updates on the rising edge.
REQ-003 SHALL have port rst  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port in_valid  input  1  the producer offers a writeback.
REQ-005 SHALL have port in_ready  output  1  the queue can accept an entry this cycle.
REQ-006 SHALL have port in_rd  input  4  the destination register index.
REQ-007 SHALL have port in_data  input  16  the writeback value.
REQ-008 SHALL have port hold  input  1  the register file write port is blocked; no pop occurs.
REQ-009 SHALL have port wr  output  1  the register-file write strobe, registered.
REQ-010 SHALL have port Rd  output  4  the register-file write index, registered.
REQ-011 SHALL have port RW  output  16  the register-file write data, registered.
REQ-012 SHALL have ports Rs and Rt  input  4 each  the read indices being issued to the register file.
REQ-013 SHALL have ports fwd1_hit and fwd2_hit  output  1 each  a pending write exists to Rs or Rt, respectively.
REQ-014 SHALL have ports fwd1_data and fwd2_data  output  16 each  the youngest pending value for Rs or Rt, respectively.
REQ-015 SHALL have port count  output  clog2(DEPTH)+1  the number of occupied entries.
REQ-016 SHALL have ports full and empty  output  1 each  count==DEPTH and count==0, respectively.

Function
REQ-017 SHALL store entries in a circular buffer addressed by head and tail pointers of width clog2(DEPTH), with wrap from DEPTH-1 to 0.
REQ-018 SHALL drive in_ready = !full, combinationally; in_ready SHALL NOT depend on a same-cycle pop.
REQ-019 SHALL push {in_rd, in_data} at the tail and increment tail when in_valid && in_ready at a clock edge.
REQ-020 SHALL pop the head entry when !empty && !hold at a clock edge, loading wr<=1, Rd<=head.rd, RW<=head.data, and incrementing head.
REQ-021 SHALL load wr<=0 at any edge without a pop, holding Rd and RW at their previous values.
REQ-022 SHALL leave count unchanged on a simultaneous push and pop, increment it on push only, and decrement it on pop only.
REQ-023 SHALL never pop an entry in the same edge it is pushed, so minimum latency is in_valid accepted at edge N -> wr=1 after edge N+1.
REQ-024 SHALL preserve write order: entries leave the queue in acceptance order, including when multiple entries target the same Rd.
REQ-025 SHALL compute forwarding combinationally over the valid queue entries plus the output stage (only while wr=1), with Rs and Rt matched independently.
REQ-026 SHALL apply forwarding priority youngest-first: the newest queue entry, then older queue entries, then the output stage; fwdN_data SHALL be 0 when fwdN_hit=0.
REQ-027 SHALL forward on index match for any register index 0..15; no register is hardwired.
REQ-028 SHALL, with hold=1 and full=1, keep all state and outputs stable except wr, which is 0.

Reset
REQ-029 SHALL, when rst=0 (asynchronous), clear head, tail and count and drive wr=0, Rd=0, RW=0, empty=1, full=0, in_ready=1, fwd1_hit=0 and fwd2_hit=0.
REQ-030 SHALL discard all queued entries on reset mid-operation, with no write strobe produced for them after rst returns to 1.
REQ-031 SHALL accept a push at the first rising edge with rst=1.

Verification
REQ-032 SHALL verify single write: push rd=3, data=0xBEEF at edge 1 with hold=0 -> wr=1, Rd=3, RW=0xBEEF after edge 2, and wr=0 after edge 3.
REQ-033 SHALL verify full queue: hold=1, push 4 entries -> full=1, in_ready=0, count=4, and a 5th in_valid is ignored; release hold -> 4 consecutive wr pulses in order.
REQ-034 SHALL verify forwarding priority: queue rd=5 data=0x0001 then rd=5 data=0x0002 with hold=1, Rs=5 -> fwd1_hit=1, fwd1_data=0x0002; Rt=6 -> fwd2_hit=0, fwd2_data=0.
REQ-035 SHALL verify simultaneous push/pop: count=2, then push and pop in the same cycle -> count stays 2, and pointers wrap correctly over 10 iterations.
REQ-036 SHALL verify output-stage forwarding: after the last entry pops (wr=1, Rd=7, RW=0x1234, queue empty), Rs=7 -> fwd1_hit=1, fwd1_data=0x1234; next cycle -> fwd1_hit=0.
REQ-037 SHALL verify reset mid-operation: 3 entries queued, rst=0 asynchronously between edges -> wr=0 immediately, count=0, and no wr pulse after release.
